// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and the alignment rule used to reject accesses.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } lsu_state_t;

  // Size 11 is treated as a misaligned access so it takes the reject path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = offset[0];
      SIZE_W:  bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges
// sub-word store data into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  byte_offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = mem_word[{byte_offset, 3'b000} +: 8];
  assign half_lane = mem_word[{byte_offset[1], 4'b0000} +: 16];

  always_comb begin
    load_value = mem_word;
    case (size)
      SIZE_B:  load_value = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SIZE_H:  load_value = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_value = mem_word;
    endcase
  end

  // Each byte lane is either overwritten by the store or kept from memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_hit;
    logic [7:0] lane_src;

    always_comb begin
      lane_hit = 1'b1;
      lane_src = store_data[8*gi +: 8];
      case (size)
        SIZE_B: begin
          lane_hit = (byte_offset == 2'(gi));
          lane_src = store_data[7:0];
        end
        SIZE_H: begin
          lane_hit = (byte_offset[1] == 1'(gi / 2));
          lane_src = store_data[8*(gi % 2) +: 8];
        end
        default: begin
          lane_hit = 1'b1;
          lane_src = store_data[8*gi +: 8];
        end
      endcase
    end

    assign merged_word[8*gi +: 8] = lane_hit ? lane_src : mem_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide synchronous-read data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int datamem_width      = 32,
  parameter int data_mem_addr_depth = 12
) (
  input  logic                           clk_150_mhz,
  input  logic                           rst,
  input  logic                           lsu_req_valid,
  output logic                           lsu_req_ready,
  input  logic [31:0]                    lsu_addr,
  input  logic                           lsu_we,
  input  logic [1:0]                     lsu_size,
  input  logic                           lsu_unsigned,
  input  logic [31:0]                    lsu_wdata,
  output logic [31:0]                    lsu_rdata,
  output logic                           lsu_done,
  output logic                           lsu_misaligned,
  output logic [data_mem_addr_depth-1:0] datamem_addr,
  output logic [datamem_width-1:0]       datamem_write_data,
  output logic                           datamem_write_en,
  input  logic [datamem_width-1:0]       datamem_data_out
);

  lsu_state_t state_reg, state_next;

  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        we_reg;
  logic        unsigned_reg;
  logic        misaligned_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic [31:0] load_value;
  logic [31:0] merged_word;
  logic        accept;
  logic        req_misaligned;

  assign accept         = (state_reg == IDLE) && lsu_req_valid;
  assign req_misaligned = is_misaligned(lsu_size, lsu_addr[1:0]);

  lsu_align u_align (
    .mem_word    (datamem_data_out),
    .byte_offset (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .store_data  (word_reg),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk_150_mhz) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (lsu_req_valid) begin
          if (req_misaligned)                    state_next = DONE;
          else if (lsu_we && lsu_size == SIZE_W) state_next = WRITE;
          else                                   state_next = READ;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = we_reg ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lsu_req_ready    = (state_reg == IDLE);
    datamem_write_en = (state_reg == WRITE);
    lsu_done         = (state_reg == DONE);
    lsu_misaligned   = (state_reg == DONE) && misaligned_reg;
  end

  // word_reg holds store data from accept, then the merged word after CAPTURE.
  always_ff @(posedge clk_150_mhz) begin
    if (rst) begin
      addr_reg       <= '0;
      size_reg       <= '0;
      we_reg         <= 1'b0;
      unsigned_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
      word_reg       <= '0;
      rdata_reg      <= '0;
    end else if (accept) begin
      addr_reg       <= lsu_addr;
      size_reg       <= lsu_size;
      we_reg         <= lsu_we;
      unsigned_reg   <= lsu_unsigned;
      misaligned_reg <= req_misaligned;
      word_reg       <= lsu_wdata;
    end else if (state_reg == CAPTURE) begin
      if (we_reg) word_reg  <= merged_word;
      else        rdata_reg <= load_value;
    end
  end

  assign datamem_addr       = addr_reg[data_mem_addr_depth+1:2];
  assign datamem_write_data = word_reg;
  assign lsu_rdata          = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// synchronous-read data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk_150_mhz = 1'b0;
  logic        rst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_misaligned;
  logic [11:0] datamem_addr;
  logic [31:0] datamem_write_data;
  logic        datamem_write_en;
  logic [31:0] datamem_data_out;

  logic [31:0] mem [0:4095];
  logic        preload_en;
  logic [11:0] preload_addr;
  logic [31:0] preload_data;

  int errors = 0;
  int checks = 0;

  always #5 clk_150_mhz = ~clk_150_mhz;

  load_store_unit dut (
    .clk_150_mhz        (clk_150_mhz),
    .rst                (rst),
    .lsu_req_valid      (lsu_req_valid),
    .lsu_req_ready      (lsu_req_ready),
    .lsu_addr           (lsu_addr),
    .lsu_we             (lsu_we),
    .lsu_size           (lsu_size),
    .lsu_unsigned       (lsu_unsigned),
    .lsu_wdata          (lsu_wdata),
    .lsu_rdata          (lsu_rdata),
    .lsu_done           (lsu_done),
    .lsu_misaligned     (lsu_misaligned),
    .datamem_addr       (datamem_addr),
    .datamem_write_data (datamem_write_data),
    .datamem_write_en   (datamem_write_en),
    .datamem_data_out   (datamem_data_out)
  );

  always @(posedge clk_150_mhz) begin
    if (preload_en)            mem[preload_addr] <= preload_data;
    else if (datamem_write_en) mem[datamem_addr] <= datamem_write_data;
    else                       datamem_data_out  <= mem[datamem_addr];
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk_150_mhz);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk_150_mhz); #1;
    preload_en = 1'b0;
  endtask

  // Issues one request and reports completion/write cycles counted from the accept edge.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int dcyc, output int wcyc, output int wcnt, output logic mis,
                        output logic [11:0] waddr, output logic [31:0] wdat,
                        output logic [11:0] addr_c1);
    dcyc = 0; wcyc = 0; wcnt = 0; mis = 1'b0; waddr = '0; wdat = '0; addr_c1 = '0;
    @(negedge clk_150_mhz);
    lsu_req_valid = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    @(posedge clk_150_mhz); #1;
    lsu_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_150_mhz);
      if (c == 1) addr_c1 = datamem_addr;
      if (datamem_write_en) begin
        wcnt++; wcyc = c; waddr = datamem_addr; wdat = datamem_write_data;
      end
      if (lsu_done) begin
        dcyc = c; mis = lsu_misaligned;
        break;
      end
    end
    $display("access we=%0b size=%0b uns=%0b addr=%h wdata=%h -> done_cyc=%0d mis=%0b writes=%0d rdata=%h",
             we, size, uns, addr, wdata, dcyc, mis, wcnt, lsu_rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_150_mhz);
    @(negedge clk_150_mhz);
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", lsu_req_ready); end
    checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", lsu_done); end
    checks++; if (lsu_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", lsu_misaligned); end
    checks++; if (datamem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", datamem_write_en); end
    checks++; if (datamem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", datamem_addr); end
    checks++; if (datamem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", datamem_write_data); end
    checks++; if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", lsu_rdata); end
    rst = 1'b0;
    $display("reset: ready=%b done=%b rdata=%h", lsu_req_ready, lsu_done, lsu_rdata);
  endtask

  task automatic test_loads();
    int d, wc, wn; logic m; logic [11:0] wa, a1; logic [31:0] wd;
    logic [31:0] exp_tab [4] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899};
    logic [1:0]  size_tab [4] = '{SIZE_B, SIZE_B, SIZE_H, SIZE_H};
    logic        uns_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] addr_tab [4] = '{32'h16, 32'h16, 32'h14, 32'h16};
    preload(12'd5, 32'h8899AABB);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, size_tab[i], uns_tab[i], addr_tab[i], 32'h0, d, wc, wn, m, wa, wd, a1);
      checks++; if (lsu_rdata !== exp_tab[i]) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, lsu_rdata, exp_tab[i]); end
      checks++; if (d !== 3) begin errors++; $display("FAIL load%0d_done_cycle got=%0d exp=3", i, d); end
      checks++; if (m !== 1'b0 || wn !== 0) begin errors++; $display("FAIL load%0d_side mis=%b writes=%0d exp mis=0 writes=0", i, m, wn); end
    end
    @(negedge clk_150_mhz);
    checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", lsu_done); end
  endtask

  task automatic test_subword_store();
    int d, wc, wn; logic m; logic [11:0] wa, a1; logic [31:0] wd;
    access(1'b1, SIZE_H, 1'b0, 32'h16, 32'h00001234, d, wc, wn, m, wa, wd, a1);
    checks++; if (wn !== 1) begin errors++; $display("FAIL sh_write_count got=%0d exp=1", wn); end
    checks++; if (wd !== 32'h1234AABB) begin errors++; $display("FAIL sh_write_data got=%h exp=1234aabb", wd); end
    checks++; if (wa !== 12'd5) begin errors++; $display("FAIL sh_write_addr got=%h exp=005", wa); end
    checks++; if (wc !== 3 || d !== 4) begin errors++; $display("FAIL sh_timing write=%0d done=%0d exp write=3 done=4", wc, d); end
    checks++; if (mem[5] !== 32'h1234AABB) begin errors++; $display("FAIL sh_mem got=%h exp=1234aabb", mem[5]); end
    access(1'b1, SIZE_B, 1'b0, 32'h15, 32'hFFFFFF77, d, wc, wn, m, wa, wd, a1);
    checks++; if (wn !== 1 || wd !== 32'h123477BB) begin errors++; $display("FAIL sb_write got=%h count=%0d exp=123477bb count=1", wd, wn); end
  endtask

  task automatic test_word();
    int d, wc, wn; logic m; logic [11:0] wa, a1; logic [31:0] wd;
    access(1'b1, SIZE_W, 1'b0, 32'h20, 32'hDEADBEEF, d, wc, wn, m, wa, wd, a1);
    checks++; if (wc !== 1 || d !== 2 || wn !== 1) begin errors++; $display("FAIL sw_timing write=%0d done=%0d count=%0d exp 1/2/1", wc, d, wn); end
    checks++; if (wa !== 12'd8 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write addr=%h data=%h exp 008/deadbeef", wa, wd); end
    access(1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, d, wc, wn, m, wa, wd, a1);
    checks++; if (lsu_rdata !== 32'hDEADBEEF || d !== 3) begin errors++; $display("FAIL lw_back rdata=%h done=%0d exp deadbeef/3", lsu_rdata, d); end
  endtask

  task automatic test_misaligned();
    int d, wc, wn; logic m; logic [11:0] wa, a1; logic [31:0] wd;
    logic [1:0]  size_tab [3] = '{SIZE_W, SIZE_H, 2'b11};
    logic [31:0] addr_tab [3] = '{32'h21, 32'h03, 32'h20};
    for (int i = 0; i < 3; i++) begin
      access(1'b1, size_tab[i], 1'b0, addr_tab[i], 32'h55555555, d, wc, wn, m, wa, wd, a1);
      checks++; if (d !== 1 || m !== 1'b1) begin errors++; $display("FAIL mis%0d_done done=%0d mis=%b exp 1/1", i, d, m); end
      checks++; if (wn !== 0) begin errors++; $display("FAIL mis%0d_write got=%0d exp=0", i, wn); end
      checks++; if (lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mis%0d_rdata got=%h exp=deadbeef", i, lsu_rdata); end
    end
    checks++; if (mem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem got=%h exp=deadbeef", mem[8]); end
    @(negedge clk_150_mhz);
    checks++; if (lsu_misaligned !== 1'b0) begin errors++; $display("FAIL mis_idle got=%b exp=0", lsu_misaligned); end
  endtask

  task automatic test_reset_abort();
    logic saw_we, saw_done;
    saw_we = 1'b0; saw_done = 1'b0;
    preload(12'd9, 32'h11223344);
    @(negedge clk_150_mhz);
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_size = SIZE_B; lsu_unsigned = 1'b0;
    lsu_addr = 32'h24; lsu_wdata = 32'h000000AA;
    @(posedge clk_150_mhz); #1;
    lsu_req_valid = 1'b0;
    @(negedge clk_150_mhz);
    @(negedge clk_150_mhz);
    rst = 1'b1;
    @(posedge clk_150_mhz); #1;
    rst = 1'b0;
    @(negedge clk_150_mhz);
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", lsu_req_ready); end
    for (int c = 0; c < 6; c++) begin
      if (datamem_write_en) saw_we = 1'b1;
      if (lsu_done) saw_done = 1'b1;
      @(negedge clk_150_mhz);
    end
    checks++; if (saw_we !== 1'b0) begin errors++; $display("FAIL abort_write got=%b exp=0", saw_we); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", saw_done); end
    checks++; if (mem[9] !== 32'h11223344) begin errors++; $display("FAIL abort_mem got=%h exp=11223344", mem[9]); end
    $display("reset_abort: write_seen=%b done_seen=%b mem9=%h", saw_we, saw_done, mem[9]);
  endtask

  task automatic test_wrap();
    int d, wc, wn; logic m; logic [11:0] wa, a1; logic [31:0] wd;
    preload(12'd4, 32'hCAFEF00D);
    access(1'b0, SIZE_W, 1'b0, 32'h4010, 32'h0, d, wc, wn, m, wa, wd, a1);
    checks++; if (a1 !== 12'h004) begin errors++; $display("FAIL wrap_addr got=%h exp=004", a1); end
    checks++; if (lsu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_rdata got=%h exp=cafef00d", lsu_rdata); end
  endtask

  initial begin
    rst = 1'b1; lsu_req_valid = 1'b0; lsu_addr = '0; lsu_we = 1'b0;
    lsu_size = SIZE_W; lsu_unsigned = 1'b0; lsu_wdata = '0;
    preload_en = 1'b0; preload_addr = '0; preload_data = '0;
    test_reset();
    test_loads();
    test_subword_store();
    test_word();
    test_misaligned();
    test_reset_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The parameter datamem_width SHALL default to 32 and give the memory word width in bits.
REQ-002 The parameter data_mem_addr_depth SHALL default to 12 and give the word-address width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk_150_mhz  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous active-high reset
- lsu_req_valid  in  1  CPU access request
- lsu_req_ready  out  1  block can accept a request
- lsu_addr  in  32  byte address
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- lsu_unsigned  in  1  zero-extend sub-word loads (LBU/LHU)
- lsu_wdata  in  32  store data, right-aligned
- lsu_rdata  out  32  load result, held until the next completion
- lsu_done  out  1  one-cycle completion pulse
- lsu_misaligned  out  1  qualifies lsu_done; access rejected
- datamem_addr  out  data_mem_addr_depth  word address to data memory
- datamem_write_data  out  datamem_width  word to write
- datamem_write_en  out  1  memory write strobe
- datamem_data_out  in  datamem_width  registered memory read data

Function
REQ-004 The block SHALL act as the initiator for a word-wide memory that registers the read data one edge after an address with write_en=0, and that performs no read on a write edge.
REQ-005 The FSM SHALL have the states IDLE, READ, CAPTURE, WRITE and DONE; lsu_req_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted on an edge where the FSM is in IDLE, lsu_req_valid=1 and rst=0; at that edge the block SHALL register the address, size, we, unsigned and wdata.
REQ-007 datamem_addr SHALL equal the registered lsu_addr[data_mem_addr_depth+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-008 A load SHALL follow IDLE->READ->CAPTURE->DONE->IDLE, with lsu_done high in the third cycle after the accept edge.
REQ-009 A word store SHALL follow IDLE->WRITE->DONE->IDLE.
REQ-010 A byte or halfword store SHALL perform a read-modify-write: IDLE->READ->CAPTURE->WRITE->DONE->IDLE.
- The merge SHALL replace only the addressed byte or halfword lane.
- The merged word SHALL be registered at the CAPTURE edge.
REQ-011 datamem_write_en SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-012 At the CAPTURE edge, loads SHALL register lsu_rdata as follows:
- Select the lane given by addr[1:0] (byte) or addr[1] (halfword).
- Sign-extend, or zero-extend if lsu_unsigned=1.
- Pass words through unchanged.
REQ-013 The following requests SHALL go IDLE->DONE with lsu_done=1 and lsu_misaligned=1, with no memory access and lsu_rdata unchanged:
- halfword with addr[0]=1
- word with addr[1:0]!=0
- lsu_size=11
REQ-014 lsu_misaligned SHALL be 0 whenever lsu_done=0.
REQ-015 Requests presented outside IDLE SHALL be ignored, and the bench SHALL NOT rely on them being queued.

Reset
REQ-016 rst SHALL take priority over every other input, including a request in the same cycle.
REQ-017 On reset the block SHALL enter IDLE and set the following outputs, all effective on the next edge:
- lsu_rdata=0
- lsu_done=0
- lsu_misaligned=0
- datamem_write_en=0
- datamem_addr=0
- datamem_write_data=0
REQ-018 A reset in any non-IDLE state SHALL abandon the access:
- no write SHALL be issued after the reset edge
- no lsu_done pulse SHALL follow for the abandoned access

Structure
REQ-019 A shared package lsu_pkg SHALL hold:
- the lsu_size encodings (SIZE_B, SIZE_H, SIZE_W)
- the FSM state enum
REQ-020 Lane extract/extend and store merge SHALL live in one combinational sub-module, lsu_align; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Preload word 5 = 0x8899AABB; LB at addr 0x16 -> lsu_rdata=0xFFFFFF99, done in cycle 3; LBU at the same addr -> 0x00000099.
- SH of 0x1234 at 0x16 over 0x8899AABB -> exactly one write of 0x1234AABB to word 5; write_en high for one cycle.
- SW of 0xDEADBEEF at 0x20 -> write in cycle 1, done in cycle 2; then LW 0x20 -> 0xDEADBEEF.
- LW at 0x21, LH at 0x03, and size=11 -> done and misaligned both pulse in cycle 1; write_en never rises; rdata unchanged.
- Assert rst while an SB is in CAPTURE -> no write_en, no done, ready=1 after reset; the memory word is unchanged.
- Address 0x4010 with data_mem_addr_depth=12 -> datamem_addr=0x004 (wrap).
